// File: rtl/alu_pkg.sv
// Shared ALU front-end definitions: default widths, button indices and opcodes.
// Used by the capture stage, the ALU itself, and the benches.
package alu_pkg;

   localparam int NB_DATA_DFLT = 4;
   localparam int NB_OP_DFLT   = 6;

   localparam int BTN_A  = 0;
   localparam int BTN_B  = 1;
   localparam int BTN_OP = 2;

   localparam logic [5:0] OP_ADD = 6'b100000;
   localparam logic [5:0] OP_SUB = 6'b100010;
   localparam logic [5:0] OP_AND = 6'b100100;
   localparam logic [5:0] OP_OR  = 6'b100101;
   localparam logic [5:0] OP_XOR = 6'b100110;
   localparam logic [5:0] OP_SRA = 6'b000011;
   localparam logic [5:0] OP_SRL = 6'b000010;
   localparam logic [5:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, level debouncer, rising-edge detect.
// Press to pulse is DEBOUNCE_CYCLES+2 edges; no backpressure, one pulse per press.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic             sync_q1;
   logic             sync_q2;
   logic             db;
   logic             db_q;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
         db      <= 1'b0;
         db_q    <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_q1 <= i_btn;
         sync_q2 <= sync_q1;
         db_q    <= db;
         if (sync_q2 == db) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            // Level held long enough: accept it; clearing here keeps cnt from wrapping.
            db  <= ~db;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign o_pulse = db & ~db_q;

endmodule

// File: rtl/alu_input_ctrl.sv
// ALU operand/opcode capture from switches on debounced button presses.
// Load lands DEBOUNCE_CYCLES+3 edges after press; no backpressure, flags sticky until reset.
module alu_input_ctrl
   import alu_pkg::*;
#(
   parameter int NB_DATA         = NB_DATA_DFLT,
   parameter int NB_OP           = NB_OP_DFLT,
   parameter int NB_SW           = 8,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic                      clk,
   input  logic                      i_rst_n,
   input  logic [NB_SW-1:0]          i_sw,
   input  logic [2:0]                i_btn,
   output logic signed [NB_DATA-1:0] o_datoA,
   output logic signed [NB_DATA-1:0] o_datoB,
   output logic [NB_OP-1:0]          o_operation,
   output logic [2:0]                o_loaded,
   output logic                      o_ready
);

   logic [NB_SW-1:0] sw_q1;
   logic [NB_SW-1:0] sw_sync;
   logic [2:0]       load;
   logic             sw_unused;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sw_q1   <= '0;
         sw_sync <= '0;
      end else begin
         sw_q1   <= i_sw;
         sw_sync <= sw_q1;
      end
   end

   // Upper switch bits are synchronised but deliberately never captured.
   assign sw_unused = ^sw_sync;

   for (genvar g = 0; g < 3; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_debounce (
         .clk     (clk),
         .i_rst_n (i_rst_n),
         .i_btn   (i_btn[g]),
         .o_pulse (load[g])
      );
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_datoA     <= '0;
         o_datoB     <= '0;
         o_operation <= '0;
         o_loaded    <= '0;
      end else begin
         if (load[BTN_A])  o_datoA     <= sw_sync[NB_DATA-1:0];
         if (load[BTN_B])  o_datoB     <= sw_sync[NB_DATA-1:0];
         if (load[BTN_OP]) o_operation <= sw_sync[NB_OP-1:0];
         o_loaded <= o_loaded | load;
      end
   end

   assign o_ready = &o_loaded;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with a short debounce window.
module tb_alu_input_ctrl;
   import alu_pkg::*;

   localparam int DB = 4;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic [7:0]        i_sw;
   logic [2:0]        i_btn;
   logic signed [3:0] o_datoA;
   logic signed [3:0] o_datoB;
   logic [5:0]        o_operation;
   logic [2:0]        o_loaded;
   logic              o_ready;

   int n_checks = 0;
   int n_errors = 0;

   alu_input_ctrl #(
      .NB_DATA         (4),
      .NB_OP           (6),
      .NB_SW           (8),
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .clk         (clk),
      .i_rst_n     (i_rst_n),
      .i_sw        (i_sw),
      .i_btn       (i_btn),
      .o_datoA     (o_datoA),
      .o_datoB     (o_datoB),
      .o_operation (o_operation),
      .o_loaded    (o_loaded),
      .o_ready     (o_ready)
   );

   always #5 clk = ~clk;

   // Reference for the downstream ALU fed by the captured registers.
   function automatic logic [3:0] alu_ref(logic signed [3:0] a, logic signed [3:0] b, logic [5:0] op);
      logic [3:0] r;
      r = '0;
      case (op)
         OP_ADD: r = a + b;
         OP_SUB: r = a - b;
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         OP_SRA: r = a >>> b;
         OP_SRL: r = a >> b;
         OP_NOR: r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int idx, input logic [7:0] sw);
      i_sw = sw;
      tick(3);
      i_btn[idx] = 1'b1;
      tick(10);
      i_btn[idx] = 1'b0;
      tick(10);
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      tick(3);
      i_rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_sw    = '0;
      i_btn   = '0;
      tick(3);
      check("rst_A",      32'($unsigned(o_datoA)), 32'd0);
      check("rst_B",      32'($unsigned(o_datoB)), 32'd0);
      check("rst_op",     32'(o_operation), 32'd0);
      check("rst_loaded", 32'(o_loaded), 32'd0);
      check("rst_ready",  32'(o_ready), 32'd0);
      i_rst_n = 1'b1;
      tick(1);

      // 1: single press, exact latency
      i_sw = 8'h03;
      tick(3);
      i_btn[0] = 1'b1;
      tick(6);
      check("t1_A_edge6", 32'($unsigned(o_datoA)), 32'd0);
      tick(1);
      check("t1_A_edge7", 32'($unsigned(o_datoA)), 32'h3);
      check("t1_loaded",  32'(o_loaded), 32'b001);
      check("t1_ready",   32'(o_ready), 32'd0);
      tick(3);
      i_btn[0] = 1'b0;
      tick(10);
      check("t1_A_release", 32'($unsigned(o_datoA)), 32'h3);

      // 2: load all three, ALU sees the operands
      press(BTN_A,  8'h06);
      press(BTN_B,  8'h03);
      press(BTN_OP, {2'b00, OP_SUB});
      check("t2_A",      32'($unsigned(o_datoA)), 32'h6);
      check("t2_B",      32'($unsigned(o_datoB)), 32'h3);
      check("t2_op",     32'(o_operation), 32'(OP_SUB));
      check("t2_loaded", 32'(o_loaded), 32'b111);
      check("t2_ready",  32'(o_ready), 32'd1);
      check("t2_alu",    32'(alu_ref(o_datoA, o_datoB, o_operation)), 32'h3);

      // 3: bounce shorter than the window is ignored
      do_reset();
      i_sw = 8'h0F;
      tick(3);
      for (int k = 0; k < 5; k++) begin
         i_btn[1] = 1'b1;
         tick(3);
         i_btn[1] = 1'b0;
         tick(3);
      end
      tick(10);
      check("t3_B",      32'($unsigned(o_datoB)), 32'd0);
      check("t3_loaded", 32'(o_loaded[1]), 32'd0);

      // 4: held button captures once, later switch changes are not reloaded
      i_sw = 8'h20;
      tick(3);
      i_btn[2] = 1'b1;
      tick(20);
      i_sw = 8'h27;
      tick(30);
      check("t4_op_held", 32'(o_operation), 32'b100000);
      i_btn[2] = 1'b0;
      tick(10);
      check("t4_op_rel",  32'(o_operation), 32'b100000);
      check("t4_loaded",  32'(o_loaded), 32'b100);

      // 5: simultaneous A and B press
      i_sw = 8'h0C;
      tick(3);
      i_btn[1:0] = 2'b11;
      tick(6);
      check("t5_A_edge6", 32'($unsigned(o_datoA)), 32'd0);
      check("t5_B_edge6", 32'($unsigned(o_datoB)), 32'd0);
      tick(1);
      check("t5_A_edge7", 32'($unsigned(o_datoA)), 32'hC);
      check("t5_B_edge7", 32'($unsigned(o_datoB)), 32'hC);
      check("t5_loaded",  32'(o_loaded), 32'b111);
      i_btn = '0;
      tick(10);

      // 6: reset mid-debounce with button still held
      i_sw = 8'h05;
      tick(3);
      i_btn[0] = 1'b1;
      tick(4);
      i_rst_n = 1'b0;
      #1;
      check("t6_rst_A",      32'($unsigned(o_datoA)), 32'd0);
      check("t6_rst_B",      32'($unsigned(o_datoB)), 32'd0);
      check("t6_rst_op",     32'(o_operation), 32'd0);
      check("t6_rst_loaded", 32'(o_loaded), 32'd0);
      check("t6_rst_ready",  32'(o_ready), 32'd0);
      tick(3);
      check("t6_rst_A_hold", 32'($unsigned(o_datoA)), 32'd0);
      i_rst_n = 1'b1;
      tick(6);
      check("t6_A_edge6", 32'($unsigned(o_datoA)), 32'd0);
      tick(1);
      check("t6_A_edge7", 32'($unsigned(o_datoA)), 32'h5);
      check("t6_loaded",  32'(o_loaded), 32'b001);
      i_btn = '0;
      tick(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
